// File: rtl/pipe_add64.sv
// Pipelined carry-segmented adder: each stage resolves one SLICE-bit segment and
// registers the carry into the next, so the critical path is a single segment.

module pipe_add64_seg #(
    parameter int SLICE = 16
) (
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] b_i,
    input  logic             c_i,
    output logic [SLICE-1:0] s_o,
    output logic             c_o
);
    localparam int NQ = SLICE / 4;

    logic [4:0] t;
    logic       cy;

    // Plain chain of 4-bit ripple slices; no lookahead between them.
    always_comb begin
        cy  = c_i;
        t   = '0;
        s_o = '0;
        for (int q = 0; q < NQ; q++) begin
            t             = {1'b0, a_i[4*q +: 4]} + {1'b0, b_i[4*q +: 4]} + {4'b0, cy};
            s_o[4*q +: 4] = t[3:0];
            cy            = t[4];
        end
        c_o = cy;
    end
endmodule

module pipe_add64 #(
    parameter int WIDTH = 64,
    parameter int SLICE = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int STAGES = WIDTH / SLICE;

    logic                         rdy_q;
    logic [STAGES:0]              vld_pipe;
    logic [STAGES-1:0]            stage_ready;
    logic [STAGES-1:0]            cy_pipe;
    logic [STAGES-1:0][WIDTH-1:0] sum_pipe;
    logic [STAGES-1:0][WIDTH-1:0] a_pipe;
    logic [STAGES-1:0][WIDTH-1:0] b_pipe;
    logic                         unused_ops;

    // Keeps in_ready low during reset and for the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_q <= 1'b0;
        else        rdy_q <= 1'b1;
    end

    assign vld_pipe[0] = in_valid && rdy_q;
    assign in_ready    = rdy_q && stage_ready[0];

    // An empty stage accepts regardless of downstream, which collapses bubbles.
    always_comb begin
        stage_ready            = '0;
        stage_ready[STAGES-1]  = !vld_pipe[STAGES] || out_ready;
        for (int k = STAGES - 2; k >= 0; k--)
            stage_ready[k] = !vld_pipe[k+1] || stage_ready[k+1];
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        logic [WIDTH-1:0] a_in, b_in, s_in, s_d;
        logic             c_in, seg_c;
        logic [SLICE-1:0] seg_s;
        logic             v_q, c_q;
        logic [WIDTH-1:0] s_q, a_q, b_q;

        if (k == 0) begin : g_head
            assign a_in = a;
            assign b_in = b;
            assign s_in = '0;
            assign c_in = cin;
        end else begin : g_body
            assign a_in = a_pipe[k-1];
            assign b_in = b_pipe[k-1];
            assign s_in = sum_pipe[k-1];
            assign c_in = cy_pipe[k-1];
        end

        pipe_add64_seg #(.SLICE(SLICE)) u_seg (
            .a_i (a_in[SLICE*k +: SLICE]),
            .b_i (b_in[SLICE*k +: SLICE]),
            .c_i (c_in),
            .s_o (seg_s),
            .c_o (seg_c)
        );

        always_comb begin
            s_d                    = s_in;
            s_d[SLICE*k +: SLICE]  = seg_s;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
                a_q <= '0;
                b_q <= '0;
            end else if (stage_ready[k]) begin
                v_q <= vld_pipe[k];
                c_q <= seg_c;
                s_q <= s_d;
                a_q <= a_in;
                b_q <= b_in;
            end
        end

        assign vld_pipe[k+1] = v_q;
        assign cy_pipe[k]    = c_q;
        assign sum_pipe[k]   = s_q;
        assign a_pipe[k]     = a_q;
        assign b_pipe[k]     = b_q;
    end

    // Last stage's operand copies have no consumer.
    assign unused_ops = ^{a_pipe[STAGES-1], b_pipe[STAGES-1]};

    assign out_valid = vld_pipe[STAGES];
    assign sum       = sum_pipe[STAGES-1];
    assign cout      = cy_pipe[STAGES-1];
endmodule

// File: tb/tb_pipe_add64.sv
// Randomized bench for pipe_add64: queue-based reference model of {cout,sum}=a+b+cin
// plus directed latency, back-pressure, bubble and mid-stream reset scenarios.
module tb_pipe_add64;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] sum;
    logic        cout;

    int checks = 0;
    int errors = 0;
    int nout = 0;
    int stream_stalls = 0;
    bit stream_phase = 0;
    logic [64:0] sb[$];
    bit          hold_v = 0;
    logic [64:0] hold_val = '0;

    pipe_add64 dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Handshakes are decided at the next rising edge; sample them mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) sb.push_back({1'b0, a} + {1'b0, b} + {64'd0, cin});
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("spurious_out", 1, 0);
                else chk("result", {cout, sum}, sb.pop_front());
                nout++;
            end
            if (out_valid && hold_v) chk("stall_hold", {cout, sum}, hold_val);
            hold_v   = out_valid && !out_ready;
            hold_val = {cout, sum};
            if (stream_phase && in_valid && !in_ready) stream_stalls++;
        end else begin
            hold_v = 0;
        end
    end

    always @(negedge rst_n) sb.delete();

    task automatic send(input logic [63:0] x, input logic [63:0] y, input logic ci);
        int n = 0;
        in_valid = 1'b1; a = x; b = y; cin = ci;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            if (++n > 200) begin chk("send_timeout", 0, 1); break; end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 || out_valid) begin
            @(negedge clk);
            if (++n > 200) begin chk("drain_timeout", 0, 1); break; end
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    initial begin
        int n0, acc;
        bit got, seen;

        // reset then idle
        repeat (3) begin
            @(negedge clk);
            chk("in_rst", {in_ready, out_valid}, 0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        repeat (10) begin
            @(negedge clk);
            chk("idle", {in_ready, out_valid, cout, sum}, {1'b1, 1'b0, 1'b0, 64'd0});
        end

        // single transfer, full ripple, latency
        @(posedge clk); #1;
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("latency", out_valid, (i == 3));
        end
        chk("ripple", {cout, sum}, {1'b1, 64'd0});
        @(negedge clk);
        chk("ripple_gone", out_valid, 0);

        // back-to-back random stream
        n0 = nout;
        @(posedge clk); #1;
        stream_phase = 1;
        for (int i = 0; i < 1000; i++)
            send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
        stream_phase = 0;
        wait_drain();
        chk("stream_stalls", stream_stalls, 0);
        chk("stream_count", nout - n0, 1000);

        // back-pressure
        n0 = nout;
        @(posedge clk); #1 out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(64'(i), 64'(i), 1'b0);
        in_valid = 1'b1; a = 64'd5; b = 64'd5; cin = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_full", in_ready, 0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        for (int i = 5; i <= 8; i++) send(64'(i), 64'(i), 1'b0);
        wait_drain();
        chk("bp_count", nout - n0, 8);

        // bubble collapse
        n0 = nout;
        @(posedge clk); #1 out_ready = 1'b0;
        send(64'd100, 64'd100, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        acc = 1;
        in_valid = 1'b1; a = 64'd101; b = 64'd101;
        repeat (6) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk); #1;
            if (got) begin acc++; a++; b++; end
        end
        in_valid = 1'b0;
        chk("bubble_accepts", acc, 4);
        repeat (20) begin
            @(posedge clk); #1 out_ready = ~out_ready;
        end
        out_ready = 1'b1;
        wait_drain();
        chk("bubble_count", nout - n0, 4);

        // reset mid-stream
        @(posedge clk); #1 out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(64'(200 + i), 64'd1, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_valid", out_valid, 1);
        #1 rst_n = 1'b0;
        #1 chk("rst_async", {out_valid, in_ready, cout, sum}, 0);
        @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
        n0 = nout;
        repeat (6) @(posedge clk);
        #1 chk("no_stale", nout - n0, 0);
        send(64'd5, 64'd7, 1'b0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1;
                chk("post_rst_sum", {cout, sum}, 65'd12);
            end
        end
        if (!seen) chk("post_rst_timeout", 0, 1);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/pipe_add64.md
Name: pipe_add64

Overview:
- Pipelined, carry-segmented 64-bit adder that sits directly downstream of the partial-product generation stage of the 64b pipeline multiplier.
- Consumes operand pairs and produces a registered sum and carry-out.
- Each pipeline stage resolves one SLICE-bit segment with a chain of 4-bit ripple-carry slices. The inter-segment carry is registered, so the critical path is one segment, not 64 bits.
- Valid/ready handshake on both sides, with bubble collapsing and back-pressure.

Parameters:
- WIDTH, 64, operand and sum width; must be a multiple of SLICE.
- SLICE, 16, bits resolved per pipeline stage; must be a multiple of 4.
- STAGES, WIDTH/SLICE (4 at defaults), derived pipeline depth; not to be overridden.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  a, b, cin valid this cycle.
- in_ready  output  1  block accepts a transfer when in_valid && in_ready.
- a  input  WIDTH  addend.
- b  input  WIDTH  addend.
- cin  input  1  carry into bit 0.
- out_valid  output  1  sum/cout valid.
- out_ready  input  1  consumer accepts when out_valid && out_ready.
- sum  output  WIDTH  a+b+cin modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low. Ports are clk and rst_n.
- Reset (rst_n=0, asynchronous):
  - All stage valid bits clear; out_valid=0.
  - sum=0, cout=0.
  - in_ready=1 one cycle after rst_n deasserts; in_ready is held 0 while rst_n=0.
  - Data registers are cleared to 0.
- Stage k (0..STAGES-1) holds:
  - a valid bit v[k];
  - a registered carry c[k];
  - sum bits [SLICE*(k+1)-1:0], already resolved;
  - the unresolved upper a/b bits [WIDTH-1:SLICE*(k+1)], skewed forward.
- Stage 0 computes bits [SLICE-1:0] from input a, b, cin.
- Stage k>0 computes bits [SLICE*(k+1)-1:SLICE*k] from its carried operand bits and c[k-1].
- Each segment is a chain of SLICE/4 4-bit ripple slices. There is no lookahead logic.
- The last stage register drives sum, cout, out_valid directly. No combinational path from a/b to outputs.
- Latency: STAGES cycles from an accepted input to out_valid, when not stalled. At defaults: input accepted at edge N, result valid after edge N+3 (4 registers).
- Throughput: one result per cycle when out_ready stays 1.
- Handshake:
  - stage_ready[STAGES-1] = !v[STAGES-1] || out_ready.
  - stage_ready[k] = !v[k] || stage_ready[k+1].
  - in_ready = stage_ready[0].
- Bubble collapsing: a stage with v=0 accepts from upstream even while downstream is stalled.
- Stage register load: stage k loads when stage_ready[k]=1. It takes the upstream valid (in_valid for k=0) and data.
- Hold on stall: when stage_ready[k]=0 the stage holds its data and valid unchanged.
- Output stability: sum/cout must not change while out_valid=1 and out_ready=0.
- in_valid=0 with stage_ready=1 loads a bubble (v=0). Data registers may update; contents are don't-care when v=0.
- Simultaneous accept and drain: the output stage loads its new value in the same cycle as the consumer handshake. No dead cycle.
- Full pipeline with out_ready=0: in_ready=0 after at most STAGES accepted transfers. No transfer is lost or duplicated.
- Wrap-around: the sum is modulo 2^WIDTH. cout carries the overflow. There are no saturation or status flags.
- Ordering: strict FIFO order is preserved.
- Reset mid-operation: all in-flight transfers are discarded; out_valid drops to 0 immediately (asynchronous).
- X handling: outputs must not be X after reset, even if in_valid=0 throughout.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release, in_valid=0 for 10 cycles -> out_valid=0, sum=0, cout=0, in_ready=1 throughout.
- Single transfer, full carry ripple: a=64'hFFFF_FFFF_FFFF_FFFF, b=0, cin=1, out_ready=1 -> out_valid after exactly 4 edges, sum=0, cout=1, then out_valid=0.
- Streaming 1000 random (a, b, cin) back-to-back, out_ready=1 -> one result per cycle in order, each matching the reference model {cout,sum}=a+b+cin, in_ready never 0.
- Back-pressure: stream 1+1, 2+2, 3+3, ... with out_ready=0 -> in_ready falls after 4 accepts. Then out_ready=1 -> results 2, 4, 6, 8, ... in order, none lost or duplicated, sum held stable while stalled.
- Bubble collapse: send one transfer, hold out_ready=0 for 6 cycles while offering more -> 4 accepts total, with the gap closed. Then toggle out_ready 1/0 per cycle -> correct ordered results.
- Reset mid-stream: 3 transfers in flight, assert rst_n low for 1 cycle -> out_valid=0 immediately, no stale result emitted afterwards, next transfer 5+7 yields sum=12, cout=0.
